// File: rtl/cnn_conv_seq.sv
// Layer-1 convolution sequencer: streams weights and biases into the PE array, then walks every
// KxK valid window of the pixel memory row-major, issuing tap reads, accumulate strobes and result writes.
module cnn_conv_seq #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int NFILT  = 8,
  parameter int PE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       w_rd_en,
  output logic [6:0] w_rd_addr,
  output logic       w_ld,
  output logic [6:0] w_ld_idx,
  output logic       b_rd_en,
  output logic [2:0] b_rd_addr,
  output logic       b_ld,
  output logic [2:0] b_ld_idx,
  output logic       px_rd_en,
  output logic [4:0] px_row,
  output logic [4:0] px_col,
  output logic       acc_en,
  output logic       acc_clr,
  output logic [3:0] tap_idx,
  output logic       res_we,
  output logic [4:0] res_row,
  output logic [4:0] res_col
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  localparam logic [6:0] W_LAST    = 7'(NFILT * K * K - 1);
  localparam logic [2:0] B_LAST    = 3'(NFILT - 1);
  localparam logic [3:0] T_LAST    = 4'(K * K - 1);
  localparam logic [4:0] K_LAST    = 5'(K - 1);
  localparam logic [4:0] R_LAST    = 5'(OUT_H - 1);
  localparam logic [4:0] C_LAST    = 5'(OUT_W - 1);
  localparam logic [3:0] WAIT_LAST = 4'(PE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_B, S_CONV, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t     state;
  logic [6:0] w_cnt;
  logic [2:0] b_cnt;
  logic [3:0] t_cnt;
  logic [4:0] tap_r, tap_c;   // t_cnt split into kernel row/column, avoids a divider
  logic [4:0] win_r, win_c;
  logic [3:0] wait_cnt;

  // Read strobes drop in the very cycle hold is high, so a held slot issues nothing.
  assign w_rd_en   = (state == S_LOAD_W) && !hold;
  assign b_rd_en   = (state == S_LOAD_B) && !hold;
  assign px_rd_en  = (state == S_CONV)   && !hold;
  assign w_rd_addr = w_cnt;
  assign b_rd_addr = b_cnt;
  assign px_row    = win_r + tap_r;
  assign px_col    = win_c + tap_c;
  assign res_we    = (state == S_WRITE);
  assign res_row   = win_r;
  assign res_col   = win_c;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // NOTE: every register here uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      w_cnt    <= '0;
      b_cnt    <= '0;
      t_cnt    <= '0;
      tap_r    <= '0;
      tap_c    <= '0;
      win_r    <= '0;
      win_c    <= '0;
      wait_cnt <= '0;
      w_ld     <= 1'b0;
      w_ld_idx <= '0;
      b_ld     <= 1'b0;
      b_ld_idx <= '0;
      acc_en   <= 1'b0;
      acc_clr  <= 1'b0;
      tap_idx  <= '0;
    end else begin
      // PE-side strobes mirror the reads one cycle later, matching the memory latency.
      w_ld     <= w_rd_en;
      w_ld_idx <= w_rd_addr;
      b_ld     <= b_rd_en;
      b_ld_idx <= b_rd_addr;
      acc_en   <= px_rd_en;
      acc_clr  <= px_rd_en && (t_cnt == '0);
      tap_idx  <= px_rd_en ? t_cnt : '0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            w_cnt <= '0;
            state <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (!hold) begin
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              b_cnt <= '0;
              state <= S_LOAD_B;
            end else begin
              w_cnt <= w_cnt + 7'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (!hold) begin
            if (b_cnt == B_LAST) begin
              b_cnt <= '0;
              win_r <= '0;
              win_c <= '0;
              t_cnt <= '0;
              tap_r <= '0;
              tap_c <= '0;
              state <= S_CONV;
            end else begin
              b_cnt <= b_cnt + 3'd1;
            end
          end
        end
        S_CONV: begin
          if (!hold) begin
            if (t_cnt == T_LAST) begin
              t_cnt    <= '0;
              tap_r    <= '0;
              tap_c    <= '0;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              t_cnt <= t_cnt + 4'd1;
              if (tap_c == K_LAST) begin
                tap_c <= '0;
                tap_r <= tap_r + 5'd1;
              end else begin
                tap_c <= tap_c + 5'd1;
              end
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_WRITE;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        S_WRITE: begin
          if (win_c == C_LAST) begin
            win_c <= '0;
            if (win_r == R_LAST) begin
              win_r <= '0;
              state <= S_DONE;
            end else begin
              win_r <= win_r + 5'd1;
              state <= S_CONV;
            end
          end else begin
            win_c <= win_c + 5'd1;
            state <= S_CONV;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_seq.sv
// Scoreboard bench for cnn_conv_seq: a reference sequence model queues every expected strobe
// (cycle, fields); a negedge monitor pops and compares whenever the DUT raises one.
module tb_cnn_conv_seq;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  localparam int BIG = 1 << 30;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, s_start = 1'b0;

  logic       busy, done, w_rd_en, w_ld, b_rd_en, b_ld, px_rd_en, acc_en, acc_clr, res_we;
  logic [6:0] w_rd_addr, w_ld_idx;
  logic [2:0] b_rd_addr, b_ld_idx;
  logic [4:0] px_row, px_col, res_row, res_col;
  logic [3:0] tap_idx;

  logic       s_busy, s_done, s_w_rd_en, s_w_ld, s_b_rd_en, s_b_ld, s_px_rd_en, s_acc_en, s_acc_clr, s_res_we;
  logic [6:0] s_w_rd_addr, s_w_ld_idx;
  logic [2:0] s_b_rd_addr, s_b_ld_idx;
  logic [4:0] s_px_row, s_px_col, s_res_row, s_res_col;
  logic [3:0] s_tap_idx;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int h_lo[2];
  int h_hi[2];
  int rst_rel = BIG;

  ev_t q_w[$], q_wl[$], q_b[$], q_bl[$], q_px[$], q_acc[$], q_res[$], q_done[$];
  ev_t q_sres[$], q_sdone[$];

  cnn_conv_seq dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_ld(w_ld), .w_ld_idx(w_ld_idx),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_ld(b_ld), .b_ld_idx(b_ld_idx),
    .px_rd_en(px_rd_en), .px_row(px_row), .px_col(px_col),
    .acc_en(acc_en), .acc_clr(acc_clr), .tap_idx(tap_idx),
    .res_we(res_we), .res_row(res_row), .res_col(res_col)
  );

  cnn_conv_seq #(.IMG_W(5), .IMG_H(5), .K(3), .NFILT(8), .PE_LAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .hold(1'b0), .busy(s_busy), .done(s_done),
    .w_rd_en(s_w_rd_en), .w_rd_addr(s_w_rd_addr), .w_ld(s_w_ld), .w_ld_idx(s_w_ld_idx),
    .b_rd_en(s_b_rd_en), .b_rd_addr(s_b_rd_addr), .b_ld(s_b_ld), .b_ld_idx(s_b_ld_idx),
    .px_rd_en(s_px_rd_en), .px_row(s_px_row), .px_col(s_px_col),
    .acc_en(s_acc_en), .acc_clr(s_acc_clr), .tap_idx(s_tap_idx),
    .res_we(s_res_we), .res_row(s_res_row), .res_col(s_res_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_ev(input string name, input bit ok, input ev_t exp, input int ga, input int gb);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: strobe at cycle %0d (a=%0d b=%0d), none required", name, cyc, ga, gb);
    end else if (exp.cyc != cyc || exp.a != ga || exp.b != gb) begin
      fails++;
      $display("FAIL %s: got cycle %0d a=%0d b=%0d, required cycle %0d a=%0d b=%0d",
               name, cyc, ga, gb, exp.cyc, exp.a, exp.b);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, w_rd_en, w_rd_addr, w_ld, w_ld_idx, b_rd_en, b_rd_addr, b_ld, b_ld_idx,
                px_rd_en, px_row, px_col, acc_en, acc_clr, tap_idx, res_we, res_row, res_col});
  endfunction

  function automatic bit held(input int t);
    for (int i = 0; i < 2; i++)
      if (t >= h_lo[i] && t <= h_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference run of the default 32x32 sequencer; relative cycle t sits at absolute n+t.
  // Read slots skip held cycles; events after rst_rel are never produced.
  task automatic model_run(input int n);
    int t = 1;
    for (int i = 0; i < 72; i++) begin
      while (held(t)) t++;
      if (t <= rst_rel)     q_w.push_back('{n + t, i, 0});
      if (t + 1 <= rst_rel) q_wl.push_back('{n + t + 1, i, 0});
      t++;
    end
    for (int i = 0; i < 8; i++) begin
      while (held(t)) t++;
      if (t <= rst_rel)     q_b.push_back('{n + t, i, 0});
      if (t + 1 <= rst_rel) q_bl.push_back('{n + t + 1, i, 0});
      t++;
    end
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 30; c++) begin
        for (int k = 0; k < 9; k++) begin
          while (held(t)) t++;
          if (t <= rst_rel)     q_px.push_back('{n + t, r + k / 3, c + k % 3});
          if (t + 1 <= rst_rel) q_acc.push_back('{n + t + 1, k, int'(k == 0)});
          t++;
        end
        t += 2;
        if (t <= rst_rel) q_res.push_back('{n + t, r, c});
        t++;
      end
    end
    if (t <= rst_rel) q_done.push_back('{n + t, 1, 0});
  endtask

  task automatic wait_rel(input int n, input int k);
    while (cyc < n + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    bit  ok;
    if (w_rd_en)  begin ok = q_w.size() != 0;   if (ok) e = q_w.pop_front();   check_ev("w_rd", ok, e, int'(w_rd_addr), 0); end
    if (w_ld)     begin ok = q_wl.size() != 0;  if (ok) e = q_wl.pop_front();  check_ev("w_ld", ok, e, int'(w_ld_idx), 0); end
    if (b_rd_en)  begin ok = q_b.size() != 0;   if (ok) e = q_b.pop_front();   check_ev("b_rd", ok, e, int'(b_rd_addr), 0); end
    if (b_ld)     begin ok = q_bl.size() != 0;  if (ok) e = q_bl.pop_front();  check_ev("b_ld", ok, e, int'(b_ld_idx), 0); end
    if (px_rd_en) begin ok = q_px.size() != 0;  if (ok) e = q_px.pop_front();  check_ev("px_rd", ok, e, int'(px_row), int'(px_col)); end
    if (acc_en)   begin ok = q_acc.size() != 0; if (ok) e = q_acc.pop_front(); check_ev("acc", ok, e, int'(tap_idx), int'(acc_clr)); end
    if (acc_clr && !acc_en) check("acc_clr_alone", 1, 0);
    if (res_we)   begin ok = q_res.size() != 0; if (ok) e = q_res.pop_front(); check_ev("res_we", ok, e, int'(res_row), int'(res_col)); end
    if (done)     begin ok = q_done.size() != 0; if (ok) e = q_done.pop_front(); check_ev("done", ok, e, int'(busy), 0); end
    if (s_res_we) begin ok = q_sres.size() != 0; if (ok) e = q_sres.pop_front(); check_ev("s_res_we", ok, e, int'(s_res_row), int'(s_res_col)); end
    if (s_done)   begin ok = q_sdone.size() != 0; if (ok) e = q_sdone.pop_front(); check_ev("s_done", ok, e, int'(s_busy), 0); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, %0d tests so far", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int n, n2, n3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", outs(), 0);
    check("s_reset_busy", s_busy, 0);

    // Run A: full run with a 5-cycle hold on tap 4 of window (3,7), start pulses while busy.
    h_lo = '{1249, -10};
    h_hi = '{1253, -20};
    rst_rel = BIG;
    @(posedge clk);
    #1;
    n = cyc;
    model_run(n);
    for (int i = 0; i < 9; i++) q_sres.push_back('{n + 80 + 11 * (i + 1), i / 3, i % 3});
    q_sdone.push_back('{n + 180, 1, 0});
    start = 1'b1;
    s_start = 1'b1;
    wait_rel(n, 1);
    start = 1'b0;
    s_start = 1'b0;
    wait_rel(n, 1249); hold = 1'b1;
    wait_rel(n, 1254); hold = 1'b0;
    wait_rel(n, 2000); start = 1'b1;
    wait_rel(n, 2001); start = 1'b0;
    check("busy_mid_run", busy, 1);
    wait_rel(n, 10886); start = 1'b1;

    // Run B: start held into the cycle after done begins a new run; reset lands on window (10,10) tap 4.
    wait_rel(n, 10887);
    n2 = cyc;
    h_lo = '{-10, -10};
    h_hi = '{-20, -20};
    rst_rel = 3805;
    model_run(n2);
    wait_rel(n2, 1); start = 1'b0;
    wait_rel(n2, 3805); rst = 1'b1;
    wait_rel(n2, 3806); rst = 1'b0;
    @(negedge clk);
    check("rst_abort_outputs", outs(), 0);

    // Run C: clean run after the abort, with holds in LOAD_W and LOAD_B.
    repeat (5) @(posedge clk);
    #1;
    n3 = cyc;
    h_lo = '{10, 76};
    h_hi = '{11, 76};
    rst_rel = BIG;
    model_run(n3);
    start = 1'b1;
    wait_rel(n3, 1);  start = 1'b0;
    wait_rel(n3, 10); hold = 1'b1;
    wait_rel(n3, 12); hold = 1'b0;
    wait_rel(n3, 76); hold = 1'b1;
    wait_rel(n3, 77); hold = 1'b0;
    wait_rel(n3, 10888);
    @(negedge clk);
    check("idle_after_run", busy, 0);

    check("left_w_rd", q_w.size(), 0);
    check("left_w_ld", q_wl.size(), 0);
    check("left_b_rd", q_b.size(), 0);
    check("left_b_ld", q_bl.size(), 0);
    check("left_px_rd", q_px.size(), 0);
    check("left_acc", q_acc.size(), 0);
    check("left_res_we", q_res.size(), 0);
    check("left_done", q_done.size(), 0);
    check("left_s_res_we", q_sres.size(), 0);
    check("left_s_done", q_sdone.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
